correct_dc_values: RTL and testbench
====================================

# correct_dc_values

Applies 2-D error diffusion to the eight chroma DC coefficients (U then V, four 4x4 blocks each) of one macroblock and quantizes them. It is the stage directly upstream of store_diffusion_errors. It fetches the macroblock's top diffusion errors from the shared top_derr RAM at column `x`, combines them with the left errors held by the store stage, and runs the serial diffuse/quantize chain. It outputs the quantized DC values and the 48-bit `derr` word that store_diffusion_errors consumes.

## Interface
- No parameters; all constants live in the shared package.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `x` in 10: macroblock column; it is the top_derr RAM address.
- `left_derr` in 32: bytes {V.l1, V.l0, U.l1, U.l0}, int8 each.
- `dc_in` in 128: eight int16 DC values; `[16k+15:16k]` = block k; k 0-3 U, 4-7 V.
- `q`, `iq` in 16 each: DC quantizer step and reciprocal, unsigned.
- `bias` in 32: rounding bias, unsigned.
- `zthresh` in 32: zero threshold, unsigned.
- `top_derr_rd_en` out 1: RAM read enable.
- `top_derr_rd_addr` out 10: RAM read address.
- `top_derr_rdata` in 32: byte layout as `left_derr`; valid one cycle after the enable.
- `dc_out` out 128: quantized DC values; layout as `dc_in`.
- `derr` out 48: bytes {V.e3, V.e2, V.e1, U.e3, U.e2, U.e1}.
- `done` out 1: one-cycle pulse; `dc_out` and `derr` are valid from this cycle.

## Operation
- FSM states: IDLE, READ, LOAD, QUANT, DONE.
- IDLE -> READ on `start`. `x`, `dc_in`, `left_derr` and the quantizer parameters are latched at that edge.
- READ: `top_derr_rd_en`=1, `top_derr_rd_addr`=latched x.
- LOAD: capture `top_derr_rdata`.
- QUANT: 3-bit step counter s runs 0..7, one quantization per cycle. ch = s[2], k = s[1:0].
- Diffusion adjustment: adj = (7*A + 8*B) >>> 3, arithmetic shift, 16-bit signed. A and B per step:
  - k0: A=top0, B=left0
  - k1: A=top1, B=e0
  - k2: A=e0, B=left1
  - k3: A=e1, B=e2
- c = dc + adj, wrapped to int16.
- Quantize: V = |c|.
  - If V > zthresh: qv = ((V*iq + bias) >> 17) * q, using 48-bit intermediates. out = ±qv truncated to int16. err = ±(V − qv) >>> 1.
  - Otherwise: out = 0, err = c >>> 1.
- err is held as signed 16-bit for chaining. Its low 8 bits go to `derr`.
- Errors e0..e3 reset per channel; e0 is never exported.
- DONE: `done`=1 for one cycle, then the FSM returns to IDLE.
- `start` is ignored outside IDLE.

## Timing
- `start` sampled at edge 0. READ is cycle 1, LOAD cycle 2, QUANT cycles 3-10, DONE cycle 11.
- Fixed 11-cycle latency. Minimum start-to-start interval is 12 cycles.
- `top_derr_rd_en` is high only in READ. `top_derr_rd_addr` holds its last value otherwise.
- `dc_out` and `derr` are registered. They update during QUANT and hold after DONE until the next QUANT. Downstream samples them only with `done`.
- Reset values: all outputs 0; FSM in IDLE; counter 0.
- Reset mid-operation aborts immediately. No `done` is produced, and there is no partial RAM access after release.

## Structure
- Shared package `dc_diff_pkg` holds:
  - C1=7, C2=8, DSHIFT=4, DSCALE=1, QFIX=17
  - state encodings
  - byte-lane index constants for the `derr`/`top_derr`/`left_derr` packing shared with store_diffusion_errors
- One combinational sub-module, `quantize_single`:
  - inputs: c, q, iq, bias, zthresh
  - outputs: out, err
- The FSM, counter and operand mux stay in the top module.

## Test plan
- All zero, zthresh=0 -> `dc_out`=0, `derr`=0, `done` exactly 11 cycles after `start`.
- U dc0=5, all else 0, zthresh=10 -> `dc_out`=0, `derr`=48'h0000_0000_0001.
- U dc0=100, q=8, iq=16384, bias=0, zthresh=0 -> `dc_out[15:0]`=96, rest 0, `derr`=48'h0000_0000_0001.
- Same parameters, dc0=−100 -> `dc_out[15:0]`=16'hFFA0, `derr`=48'h0000_00FF_FFFF.
- x=37, RAM word 32'h0000_0808, left=0, dc=0, zthresh=32'h7FFF:
  - `top_derr_rd_addr`=37 with en=1 in cycle 1 only.
  - `derr`=48'h0000_0002_0105; `dc_out`=0.
- Second `start` during QUANT is ignored. `rst_n` low in cycle 6 -> all outputs 0 and no `done`; a new `start` after release gives a normal result.

Source files
------------

// File: rtl/dc_diff_pkg.sv
// dc_diff_pkg: constants, state encoding and byte-lane helpers shared by the chroma DC diffusion stages
package dc_diff_pkg;
    localparam int C1 = 7;
    localparam int C2 = 8;
    localparam int DSHIFT = 4;
    localparam int DSCALE = 1;
    localparam int QFIX = 17;
    localparam int ASHIFT = DSHIFT - DSCALE;
    typedef enum logic [2:0] {IDLE, READ, LOAD, QUANT, DONE} state_t;
    localparam int LANE_U0 = 0;
    localparam int LANE_U1 = 1;
    localparam int LANE_V0 = 2;
    localparam int LANE_V1 = 3;
    localparam int DERR_U1 = 0;
    localparam int DERR_V1 = 3;
    function automatic logic [15:0] lane_s16(input logic [31:0] w, input logic ch, input logic i);
        logic [7:0] b;
        b = w[8*(ch ? (i ? LANE_V1 : LANE_V0) : (i ? LANE_U1 : LANE_U0)) +: 8];
        return {{8{b[7]}}, b};
    endfunction
endpackage

// File: rtl/quantize_single.sv
// quantize_single: quantizes one diffused DC value and returns its output and signed residual error
module quantize_single
    import dc_diff_pkg::*;
(
    input  logic [15:0] c,
    input  logic [15:0] q,
    input  logic [15:0] iq,
    input  logic [31:0] bias,
    input  logic [31:0] zthresh,
    output logic [15:0] out,
    output logic [15:0] err
);
    logic neg, hit;
    logic [16:0] v;
    logic [47:0] qv;
    logic signed [47:0] diff, sdiff;
    always_comb begin
        neg = c[15];
        v = neg ? 17'(-$signed({1'b1, c})) : {1'b0, c};
        hit = 32'(v) > zthresh;
        qv = (((48'(v) * 48'(iq)) + 48'(bias)) >> QFIX) * 48'(q);
        diff = $signed(48'(v) - qv);
        sdiff = neg ? -diff : diff;
        out = hit ? (neg ? 16'(-qv) : qv[15:0]) : '0;
        err = hit ? 16'(sdiff >>> DSCALE) : 16'($signed(c) >>> DSCALE);
    end
endmodule

// File: rtl/correct_dc_values.sv
// correct_dc_values: fetches top errors, diffuses and quantizes the eight chroma DC values of a macroblock
module correct_dc_values
    import dc_diff_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [9:0]   x,
    input  logic [31:0]  left_derr,
    input  logic [127:0] dc_in,
    input  logic [15:0]  q,
    input  logic [15:0]  iq,
    input  logic [31:0]  bias,
    input  logic [31:0]  zthresh,
    output logic         top_derr_rd_en,
    output logic [9:0]   top_derr_rd_addr,
    input  logic [31:0]  top_derr_rdata,
    output logic [127:0] dc_out,
    output logic [47:0]  derr,
    output logic         done
);
    state_t state_q, state_d;
    logic [2:0] s_q, s_d;
    logic [9:0] x_q, x_d;
    logic [127:0] dc_q, dc_d, dc_out_q, dc_out_d;
    logic [31:0] left_q, left_d, top_q, top_d, bias_q, bias_d, zth_q, zth_d;
    logic [15:0] q_q, q_d, iq_q, iq_d;
    logic [15:0] e_q [4];
    logic [15:0] e_d [4];
    logic [47:0] derr_q, derr_d;
    logic ch, load;
    logic [1:0] k;
    logic [15:0] a, b, adj, c, qout, qerr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= '0;
            x_q      <= '0;
            dc_q     <= '0;
            left_q   <= '0;
            top_q    <= '0;
            q_q      <= '0;
            iq_q     <= '0;
            bias_q   <= '0;
            zth_q    <= '0;
            e_q      <= '{default: '0};
            dc_out_q <= '0;
            derr_q   <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            x_q      <= x_d;
            dc_q     <= dc_d;
            left_q   <= left_d;
            top_q    <= top_d;
            q_q      <= q_d;
            iq_q     <= iq_d;
            bias_q   <= bias_d;
            zth_q    <= zth_d;
            e_q      <= e_d;
            dc_out_q <= dc_out_d;
            derr_q   <= derr_d;
        end
    end

    always_comb begin
        state_d = state_q == IDLE  ? (start ? READ : IDLE) :
                  state_q == READ  ? LOAD :
                  state_q == LOAD  ? QUANT :
                  state_q == QUANT ? (s_q == 3'd7 ? DONE : QUANT) : IDLE;
    end

    // Operand mux: k0/k2 pull from the stored top/left bytes, k1/k3 chain earlier errors of this channel
    always_comb begin
        ch = s_q[2];
        k = s_q[1:0];
        a = k == 2'd0 ? lane_s16(top_q, ch, 1'b0) : k == 2'd1 ? lane_s16(top_q, ch, 1'b1) :
            k == 2'd2 ? e_q[0] : e_q[1];
        b = k == 2'd0 ? lane_s16(left_q, ch, 1'b0) : k == 2'd1 ? e_q[0] :
            k == 2'd2 ? lane_s16(left_q, ch, 1'b1) : e_q[2];
        adj = 16'((C1 * $signed(a) + C2 * $signed(b)) >>> ASHIFT);
        c = dc_q[{s_q, 4'b0} +: 16] + adj;
    end

    quantize_single u_quant (
        .c      (c),
        .q      (q_q),
        .iq     (iq_q),
        .bias   (bias_q),
        .zthresh(zth_q),
        .out    (qout),
        .err    (qerr)
    );

    always_comb begin
        load = state_q == IDLE && start;
        x_d = load ? x : x_q;
        dc_d = load ? dc_in : dc_q;
        left_d = load ? left_derr : left_q;
        q_d = load ? q : q_q;
        iq_d = load ? iq : iq_q;
        bias_d = load ? bias : bias_q;
        zth_d = load ? zthresh : zth_q;
        top_d = state_q == LOAD ? top_derr_rdata : top_q;
        s_d = state_q == QUANT ? s_q + 3'd1 : s_q;
        e_d = e_q;
        dc_out_d = dc_out_q;
        derr_d = derr_q;
        if (state_q == QUANT) begin
            dc_out_d[{s_q, 4'b0} +: 16] = qout;
            e_d[k] = qerr;
            if (k != 2'd0) derr_d[8*((ch ? DERR_V1 : DERR_U1) + int'(k) - 1) +: 8] = qerr[7:0];
        end
    end

    assign top_derr_rd_en = state_q == READ;
    assign top_derr_rd_addr = x_q;
    assign dc_out = dc_out_q;
    assign derr = derr_q;
    assign done = state_q == DONE;
endmodule

// File: tb/tb_correct_dc_values.sv
// tb_correct_dc_values: directed vector bench for correct_dc_values with a registered top_derr RAM model
module tb_correct_dc_values;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [9:0]   x = '0;
    logic [31:0]  left_derr = '0;
    logic [127:0] dc_in = '0;
    logic [15:0]  q = '0;
    logic [15:0]  iq = '0;
    logic [31:0]  bias = '0;
    logic [31:0]  zthresh = '0;
    logic         top_derr_rd_en;
    logic [9:0]   top_derr_rd_addr;
    logic [31:0]  top_derr_rdata = '0;
    logic [127:0] dc_out;
    logic [47:0]  derr;
    logic         done;
    logic [9:0]   ram_addr = '0;
    logic [31:0]  ram_word = '0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [127:0] dc;
        logic [31:0]  left;
        logic [31:0]  word;
        logic [9:0]   x;
        logic [15:0]  q;
        logic [15:0]  iq;
        logic [31:0]  bias;
        logic [31:0]  zth;
        logic [127:0] exp_dc;
        logic [47:0]  exp_derr;
    } vec_t;
    vec_t vecs [8];

    correct_dc_values dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .left_derr(left_derr), .dc_in(dc_in),
        .q(q), .iq(iq), .bias(bias), .zthresh(zthresh), .top_derr_rd_en(top_derr_rd_en),
        .top_derr_rd_addr(top_derr_rd_addr), .top_derr_rdata(top_derr_rdata),
        .dc_out(dc_out), .derr(derr), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (top_derr_rd_en) top_derr_rdata <= (top_derr_rd_addr == ram_addr) ? ram_word : 32'hA5A5_A5A5;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string name, input int poke);
        int cyc;
        int en_cnt;
        int extra;
        dc_in = v.dc; left_derr = v.left; x = v.x; q = v.q; iq = v.iq; bias = v.bias; zthresh = v.zth;
        ram_addr = v.x; ram_word = v.word;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dc_in = ~v.dc; left_derr = ~v.left; x = ~v.x; q = ~v.q; iq = ~v.iq; bias = ~v.bias; zthresh = ~v.zth;
        cyc = 1;
        en_cnt = 0;
        while (1) begin
            if (top_derr_rd_en) begin
                en_cnt++;
                chk({name, "_rd_cycle"}, 128'(cyc), 128'd1);
                chk({name, "_rd_addr"}, 128'(top_derr_rd_addr), 128'(v.x));
            end
            if (done || cyc >= 20) break;
            if (cyc == poke) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk({name, "_done_cycle"}, 128'(cyc), 128'd11);
        chk({name, "_rd_count"}, 128'(en_cnt), 128'd1);
        chk({name, "_dc_out"}, dc_out, v.exp_dc);
        chk({name, "_derr"}, 128'(derr), 128'(v.exp_derr));
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, 128'(done), 128'd0);
        if (poke != 0) begin
            extra = 0;
            repeat (14) begin
                @(posedge clk); #1;
                if (done || top_derr_rd_en) extra++;
            end
            chk({name, "_ignored_start"}, 128'(extra), 128'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        vecs[0] = '{128'h0, 32'h0, 32'h0, 10'd3, 16'd0, 16'd0, 32'd0, 32'd0, 128'h0, 48'h0};
        vecs[1] = '{128'h5, 32'h0, 32'h0, 10'd4, 16'd0, 16'd0, 32'd0, 32'd10, 128'h0, 48'h0000_0000_0001};
        vecs[2] = '{128'h64, 32'h0, 32'h0, 10'd5, 16'd8, 16'd16384, 32'd0, 32'd0, 128'h60, 48'h0000_0000_0001};
        vecs[3] = '{128'hFF9C, 32'h0, 32'h0, 10'd6, 16'd8, 16'd16384, 32'd0, 32'd0, 128'hFFA0,
                    48'h0000_00FF_FFFF};
        vecs[4] = '{128'h0, 32'h0, 32'h0000_0808, 10'd37, 16'd0, 16'd0, 32'd0, 32'h7FFF, 128'h0,
                    48'h0000_0002_0105};
        vecs[5] = '{128'h0, 32'h0, 32'h0808_0000, 10'd999, 16'd0, 16'd0, 32'd0, 32'h7FFF, 128'h0,
                    48'h0201_0500_0000};
        vecs[6] = '{128'h0, 32'h0000_0008, 32'h0, 10'd0, 16'd0, 16'd0, 32'd0, 32'h7FFF, 128'h0,
                    48'h0000_0001_0102};
        vecs[7] = '{128'h0000_0000_0000_FC18_03EE_0000_0000_0000, 32'h0, 32'h0, 10'd12, 16'd10, 16'd13107,
                    32'd65536, 32'd0, 128'h0000_0000_0000_FC18_03F2_0000_0000_0000, 48'h0000_00FE_0000};
        #22;
        chk("reset_dc_out", dc_out, 128'h0);
        chk("reset_derr", 128'(derr), 128'h0);
        chk("reset_ctrl", 128'({done, top_derr_rd_en, top_derr_rd_addr}), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) run(vecs[i], $sformatf("vec%0d", i), 0);
        run(vecs[4], "restart", 5);
        start = 1'b0;
        dc_in = vecs[2].dc; left_derr = '0; x = vecs[2].x; q = vecs[2].q; iq = vecs[2].iq;
        bias = '0; zthresh = '0; ram_addr = vecs[2].x; ram_word = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_reset_dc0", 128'(dc_out[15:0]), 128'h60);
        rst_n = 1'b0;
        #1;
        chk("midreset_dc_out", dc_out, 128'h0);
        chk("midreset_derr", 128'(derr), 128'h0);
        chk("midreset_ctrl", 128'({done, top_derr_rd_en, top_derr_rd_addr}), 128'h0);
        n = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
            if (done || top_derr_rd_en) n++;
        end
        chk("midreset_no_done", 128'(n), 128'd0);
        run(vecs[7], "post_reset", 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
